wb_port_arbiter: RTL and testbench

- Owns the single register-file write port: WE3, A3 and the registered write-back data toWD3.
- Shares that port between two requesters:
  - the main pipeline write-back stage, which normally has priority;
  - the multi-cycle mul/div unit (MDU), whose results queue in a small FIFO.
- A starvation counter guarantees MDU progress by stalling the pipeline for one cycle.
- Busy-lookup outputs let the hazard unit detect reads of, or writes to, registers with a pending MDU write.

---
 rtl/wb_port_arbiter.sv | 129 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back vs. queued mul/div results.
// Pipeline normally wins; a starvation counter forces one MDU grant after STARVE_MAX losses.
module wb_port_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_A3,
  input  logic [31:0] pipe_WD3,
  output logic        pipe_stall,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_A3,
  input  logic [31:0] mdu_WD3,
  output logic        mdu_ready,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  rd_addr,
  output logic        rs_busy,
  output logic        rt_busy,
  output logic        rd_busy,
  output logic        WE3,
  output logic [4:0]  A3,
  output logic [31:0] toWD3
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [PW:0]   DEPTH_C     = (PW + 1)'(DEPTH);
  localparam logic [CW-1:0] STARVE_LAST = CW'(STARVE_MAX - 1);

  logic [4:0]       fifo_a [DEPTH];
  logic [31:0]      fifo_d [DEPTH];
  logic [DEPTH-1:0] fifo_vld;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;
  logic [CW-1:0]    starve_cnt;
  logic             force_q;

  logic fifo_empty, pipe_req_p0, grant_pipe_p0, grant_fifo_p0, push_p0;

  // Stage p0: grant selection and FIFO handshake
  assign fifo_empty    = (count == '0);
  assign pipe_req_p0   = pipe_we && (pipe_A3 != 5'd0);
  assign grant_fifo_p0 = force_q || (!pipe_req_p0 && !fifo_empty);
  assign grant_pipe_p0 = !force_q && pipe_req_p0;
  assign mdu_ready     = !reset && (count < DEPTH_C);
  // Writes to r0 are accepted but never queued.
  assign push_p0       = mdu_valid && mdu_ready && (mdu_A3 != 5'd0);
  assign pipe_stall    = force_q;

  always_comb begin
    rs_busy = 1'b0;
    rt_busy = 1'b0;
    rd_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_vld[i]) begin
        if (fifo_a[i] == rs_addr) rs_busy = 1'b1;
        if (fifo_a[i] == rt_addr) rt_busy = 1'b1;
        if (fifo_a[i] == rd_addr) rd_busy = 1'b1;
      end
    end
    if (rs_addr == 5'd0) rs_busy = 1'b0;
    if (rt_addr == 5'd0) rt_busy = 1'b0;
    if (rd_addr == 5'd0) rd_busy = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (push_p0) begin
      fifo_a[wr_ptr] <= mdu_A3;
      fifo_d[wr_ptr] <= mdu_WD3;
    end
  end

  // Stage p1: FIFO control, starvation tracking and the write-port register
  always_ff @(posedge CLK) begin
    if (reset) begin
      WE3        <= 1'b0;
      A3         <= 5'd0;
      toWD3      <= 32'd0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_vld   <= '0;
      starve_cnt <= '0;
      force_q    <= 1'b0;
    end else begin
      if (grant_fifo_p0) begin
        WE3   <= 1'b1;
        A3    <= fifo_a[rd_ptr];
        toWD3 <= fifo_d[rd_ptr];
      end else if (grant_pipe_p0) begin
        WE3   <= 1'b1;
        A3    <= pipe_A3;
        toWD3 <= pipe_WD3;
      end else begin
        WE3 <= 1'b0;
      end

      if (push_p0) begin
        fifo_vld[wr_ptr] <= 1'b1;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (grant_fifo_p0) begin
        fifo_vld[rd_ptr] <= 1'b0;
        rd_ptr           <= rd_ptr + 1'b1;
      end
      case ({push_p0, grant_fifo_p0})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      force_q <= 1'b0;
      if (grant_fifo_p0 || fifo_empty) begin
        starve_cnt <= '0;
      end else if (grant_pipe_p0) begin
        if (starve_cnt == STARVE_LAST) begin
          starve_cnt <= '0;
          force_q    <= 1'b1;
        end else begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (DEPTH=2, STARVE_MAX=4) with hand-computed expectations.
module tb_wb_port_arbiter;

  logic        CLK = 1'b0;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_A3;
  logic [31:0] pipe_WD3;
  logic        pipe_stall;
  logic        mdu_valid;
  logic [4:0]  mdu_A3;
  logic [31:0] mdu_WD3;
  logic        mdu_ready;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic        rs_busy, rt_busy, rd_busy;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] toWD3;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mdu_log [$];
  int c_writes;
  int j;
  logic [4:0]  pa;
  logic [4:0]  ea;
  logic [31:0] ed;
  logic        rdy, stall_now;

  always #5 CLK = ~CLK;

  wb_port_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .CLK(CLK), .reset(reset),
    .pipe_we(pipe_we), .pipe_A3(pipe_A3), .pipe_WD3(pipe_WD3), .pipe_stall(pipe_stall),
    .mdu_valid(mdu_valid), .mdu_A3(mdu_A3), .mdu_WD3(mdu_WD3), .mdu_ready(mdu_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .rd_busy(rd_busy),
    .WE3(WE3), .A3(A3), .toWD3(toWD3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    pipe_we = 1'b1; pipe_A3 = 5'd3; pipe_WD3 = 32'd33;
    mdu_valid = 1'b1; mdu_A3 = 5'd9; mdu_WD3 = 32'd99;
    rs_addr = 5'd0; rt_addr = 5'd0; rd_addr = 5'd0;

    // Reset held two cycles with both requesters active
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_we3", 32'(WE3), 32'd0);
      chk("rst_a3", 32'(A3), 32'd0);
      chk("rst_wd3", toWD3, 32'd0);
      chk("rst_ready", 32'(mdu_ready), 32'd0);
      chk("rst_stall", 32'(pipe_stall), 32'd0);
    end
    reset = 1'b0; pipe_we = 1'b0; mdu_valid = 1'b0; rs_addr = 5'd9;
    #1;
    chk("post_rst_ready", 32'(mdu_ready), 32'd1);
    chk("post_rst_busy", 32'(rs_busy), 32'd0);
    tick();
    chk("post_rst_we3_a", 32'(WE3), 32'd0);
    tick();
    chk("post_rst_we3_b", 32'(WE3), 32'd0);

    // Pipeline-only writes, then a discarded r0 write
    pipe_we = 1'b1; pipe_A3 = 5'd5; pipe_WD3 = 32'hDEADBEEF;
    tick();
    chk("pipe_we3", 32'(WE3), 32'd1);
    chk("pipe_a3", 32'(A3), 32'd5);
    chk("pipe_wd3", toWD3, 32'hDEADBEEF);
    pipe_A3 = 5'd6; pipe_WD3 = 32'h11111111;
    tick();
    chk("pipe_a3_b", 32'(A3), 32'd6);
    pipe_A3 = 5'd0; pipe_WD3 = 32'h22222222;
    tick();
    chk("r0_we3", 32'(WE3), 32'd0);
    chk("r0_a3_hold", 32'(A3), 32'd6);
    chk("r0_wd3_hold", toWD3, 32'h11111111);
    pipe_we = 1'b0;

    // Idle MDU grant with busy lookup
    mdu_valid = 1'b1; mdu_A3 = 5'd7; mdu_WD3 = 32'h12345678; rt_addr = 5'd7;
    #1;
    chk("idle_busy_pre", 32'(rt_busy), 32'd0);
    tick();
    mdu_valid = 1'b0;
    chk("idle_busy_q", 32'(rt_busy), 32'd1);
    chk("idle_we3_q", 32'(WE3), 32'd0);
    tick();
    chk("idle_busy_post", 32'(rt_busy), 32'd0);
    chk("idle_we3", 32'(WE3), 32'd1);
    chk("idle_a3", 32'(A3), 32'd7);
    chk("idle_wd3", toWD3, 32'h12345678);

    // MDU result for r0 is accepted but never written
    mdu_valid = 1'b1; mdu_A3 = 5'd0; mdu_WD3 = 32'h55;
    #1;
    chk("mdu_r0_ready", 32'(mdu_ready), 32'd1);
    tick();
    mdu_valid = 1'b0;
    tick();
    chk("mdu_r0_we3", 32'(WE3), 32'd0);
    chk("mdu_r0_a3", 32'(A3), 32'd7);

    // Starvation: one MDU push against a continuously writing pipeline
    rd_addr = 5'd8; mdu_A3 = 5'd8; mdu_WD3 = 32'hA0000008; pipe_we = 1'b1;
    for (int i = 0; i < 7; i++) begin
      mdu_valid = (i == 0);
      pipe_A3 = (i <= 5) ? 5'(10 + i) : 5'd15;
      pipe_WD3 = 32'h100 + 32'(pipe_A3);
      #1;
      chk("starve_rd_busy", 32'(rd_busy), ((i >= 1) && (i <= 5)) ? 32'd1 : 32'd0);
      tick();
      if (i == 5) begin
        ea = 5'd8; ed = 32'hA0000008;
      end else begin
        ea = (i < 5) ? 5'(10 + i) : 5'd15;
        ed = 32'h100 + 32'(ea);
      end
      chk("starve_we3", 32'(WE3), 32'd1);
      chk("starve_a3", 32'(A3), 32'(ea));
      chk("starve_wd3", toWD3, ed);
      chk("starve_stall", 32'(pipe_stall), (i == 4) ? 32'd1 : 32'd0);
    end
    pipe_we = 1'b0; mdu_valid = 1'b0;
    tick();
    chk("starve_idle_we3", 32'(WE3), 32'd0);

    // Backpressure and ordering with three back-to-back MDU results
    j = 0; pa = 5'd1; pipe_we = 1'b1;
    for (int i = 0; i < 17; i++) begin
      pipe_A3 = pa;
      pipe_WD3 = 32'h200 + 32'(pa);
      mdu_valid = (j < 3);
      mdu_A3 = 5'(20 + j);
      mdu_WD3 = 32'hB0000001 + 32'(j);
      #1;
      rdy = mdu_ready;
      stall_now = pipe_stall;
      chk("bp_stall", 32'(pipe_stall), ((i == 5) || (i == 10) || (i == 15)) ? 32'd1 : 32'd0);
      if (i == 2) chk("bp_ready_full", 32'(mdu_ready), 32'd0);
      if (i == 5) chk("bp_ready_pop", 32'(mdu_ready), 32'd0);
      if (i == 6) chk("bp_ready_free", 32'(mdu_ready), 32'd1);
      tick();
      if (mdu_valid && rdy) j++;
      if (!stall_now) pa = pa + 5'd1;
      if (WE3 && (toWD3[31:28] == 4'hB)) mdu_log.push_back(toWD3);
    end
    mdu_valid = 1'b0;
    chk("bp_accepted", 32'(j), 32'd3);
    chk("bp_log_size", 32'(mdu_log.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < mdu_log.size()) chk("bp_order", mdu_log[k], 32'hB0000001 + 32'(k));
    end

    // Reset while two results are queued
    mdu_valid = 1'b1; mdu_A3 = 5'd24; mdu_WD3 = 32'hC0000001;
    pipe_A3 = 5'd2; pipe_WD3 = 32'h302;
    tick();
    mdu_A3 = 5'd25; mdu_WD3 = 32'hC0000002; pipe_A3 = 5'd3; pipe_WD3 = 32'h303;
    tick();
    mdu_valid = 1'b0; rs_addr = 5'd24; rt_addr = 5'd25;
    #1;
    chk("mq_busy_rs", 32'(rs_busy), 32'd1);
    chk("mq_busy_rt", 32'(rt_busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0; pipe_we = 1'b0;
    #1;
    chk("mq_we3", 32'(WE3), 32'd0);
    chk("mq_rs_clear", 32'(rs_busy), 32'd0);
    chk("mq_rt_clear", 32'(rt_busy), 32'd0);
    chk("mq_ready", 32'(mdu_ready), 32'd1);
    c_writes = 0;
    repeat (8) begin
      tick();
      if (WE3) c_writes++;
    end
    chk("mq_no_write", 32'(c_writes), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
